regs: RTL and testbench

Architectural integer register file for the RV32I core. It sits directly downstream of the `ex` stage and takes its `rd_addr`/`rd_data`/`rd_wen` write-back. It supplies the two source-operand read ports used by decode, with same-cycle write forwarding. A debug access port with a req/ack handshake arbitrates against pipeline write-back and can request a pipeline stall when starved.

---
 rtl/regs_pkg.sv | 22 ++
 rtl/regs_dbg_arb.sv | 88 ++++++++
 rtl/regs.sv | 120 ++++++++++++
 tb/tb_regs.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regs_pkg.sv
// regs_pkg
// Shared constants for the RV32I architectural register file and its
// debug arbiter: register file geometry, the hardwired-zero register
// index and the debug handshake FSM state encodings.
package regs_pkg;

    localparam int REG_NUM    = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    // x0 reads as zero and ignores writes
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    // Consecutive denied debug cycles before a stall is requested
    localparam int DBG_STARVE_MAX_DEF = 8;

    // Debug handshake FSM encodings
    localparam logic [1:0] DBG_IDLE     = 2'd0;
    localparam logic [1:0] DBG_ACK      = 2'd1;
    localparam logic [1:0] DBG_WAIT_LOW = 2'd2;

endpackage

// File: rtl/regs_dbg_arb.sv
// regs_dbg_arb
// Arbitrates the debug access port against pipeline write-back. Write-back
// always wins; a pending debug request is granted only in a cycle with no
// write-back. Tracks how long a request has been starved and raises a
// registered stall request once the starvation limit is reached.
//
// Ports:
//   clk, rst_n   core clock, asynchronous active-low reset
//   i_dbg_req    debug request, held until ack
//   i_reg_wen    pipeline write-back enable (takes priority)
//   o_grant      one-cycle combinational grant to the array logic
//   o_ack        registered one-cycle completion pulse
//   o_hold       registered stall request to ctrl
module regs_dbg_arb
    import regs_pkg::*;
#(
    parameter int DBG_STARVE_MAX = DBG_STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_dbg_req,
    input  logic i_reg_wen,
    output logic o_grant,
    output logic o_ack,
    output logic o_hold
);

    localparam logic [7:0] STARVE_MAX = 8'(DBG_STARVE_MAX);

    logic [1:0] r_state;
    logic [7:0] r_starve;
    logic       r_ack;
    logic       r_hold;
    logic       w_grant;

    // A request is serviced only from IDLE and only when write-back is idle
    assign w_grant = (r_state == DBG_IDLE) && i_dbg_req && !i_reg_wen;

    assign o_grant = w_grant;
    assign o_ack   = r_ack;
    assign o_hold  = r_hold;

    // The ack is the grant delayed by one edge, so it is high exactly in the
    // ACK state. WAIT_LOW keeps a still-held request from being executed again.
    // Hold rises on the edge where the starve count reaches the limit and
    // stays up through the grant cycle, dropping on the edge into ACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= DBG_IDLE;
            r_starve <= '0;
            r_ack    <= 1'b0;
            r_hold   <= 1'b0;
        end else begin
            r_ack <= w_grant;
            case (r_state)
                DBG_IDLE: begin
                    if (!i_dbg_req) begin
                        r_starve <= '0;
                        r_hold   <= 1'b0;
                    end else if (i_reg_wen) begin
                        if (r_starve != STARVE_MAX) begin
                            r_starve <= r_starve + 8'd1;
                        end
                        if (r_starve >= STARVE_MAX - 8'd1) begin
                            r_hold <= 1'b1;
                        end
                    end else begin
                        r_starve <= '0;
                        r_hold   <= 1'b0;
                        r_state  <= DBG_ACK;
                    end
                end
                DBG_ACK: begin
                    r_state <= DBG_WAIT_LOW;
                end
                DBG_WAIT_LOW: begin
                    if (!i_dbg_req) begin
                        r_state <= DBG_IDLE;
                    end
                end
                default: begin
                    r_state <= DBG_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/regs.sv
// regs
// Architectural integer register file for the RV32I core. Two combinational
// read ports for decode with same-cycle forwarding of the write-back value,
// one write-back port from ex, and a debug access port (req/ack) that only
// gets the array when write-back is idle. x0 is hardwired to zero.
//
// Ports:
//   clk, rst_n                    core clock, asynchronous active-low reset
//   reg1_raddr_i / reg1_rdata_o   read port 1 address / data (combinational)
//   reg2_raddr_i / reg2_rdata_o   read port 2 address / data (combinational)
//   reg_waddr_i, reg_wdata_i,
//   reg_wen_i                     write-back from ex
//   dbg_req_i, dbg_we_i,
//   dbg_addr_i, dbg_wdata_i       debug request, held until dbg_ack_o
//   dbg_ack_o                     registered one-cycle completion pulse
//   dbg_rdata_o                   registered debug read result
//   dbg_hold_o                    registered stall request to ctrl
module regs
    import regs_pkg::*;
#(
    parameter int REG_NUM        = regs_pkg::REG_NUM,
    parameter int ADDR_W         = REG_ADDR_W,
    parameter int DATA_W         = REG_DATA_W,
    parameter int DBG_STARVE_MAX = DBG_STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] reg1_raddr_i,
    input  logic [ADDR_W-1:0] reg2_raddr_i,
    output logic [DATA_W-1:0] reg1_rdata_o,
    output logic [DATA_W-1:0] reg2_rdata_o,
    input  logic [ADDR_W-1:0] reg_waddr_i,
    input  logic [DATA_W-1:0] reg_wdata_i,
    input  logic              reg_wen_i,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_ack_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_hold_o
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] r_regs [0:REG_NUM-1];
    logic [DATA_W-1:0] r_dbg_rdata;
    logic              w_grant;
    logic              w_pipe_we;
    logic              w_dbg_we;
    logic              w_dbg_re;
    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;

    regs_dbg_arb #(
        .DBG_STARVE_MAX(DBG_STARVE_MAX)
    ) u_dbg_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_dbg_req(dbg_req_i),
        .i_reg_wen(reg_wen_i),
        .o_grant  (w_grant),
        .o_ack    (dbg_ack_o),
        .o_hold   (dbg_hold_o)
    );

    assign w_pipe_we = reg_wen_i && (reg_waddr_i != ZERO_ADDR);
    assign w_dbg_we  = w_grant && dbg_we_i && (dbg_addr_i != ZERO_ADDR);
    assign w_dbg_re  = w_grant && !dbg_we_i;

    // Read port 1: zero for x0, then the in-flight write-back value when it
    // targets the same register, otherwise the stored value
    always_comb begin
        w_rdata1 = r_regs[reg1_raddr_i];
        if (reg1_raddr_i == ZERO_ADDR) begin
            w_rdata1 = '0;
        end else if (reg_wen_i && (reg_waddr_i == reg1_raddr_i)) begin
            w_rdata1 = reg_wdata_i;
        end
    end

    // Read port 2: same selection as port 1
    always_comb begin
        w_rdata2 = r_regs[reg2_raddr_i];
        if (reg2_raddr_i == ZERO_ADDR) begin
            w_rdata2 = '0;
        end else if (reg_wen_i && (reg_waddr_i == reg2_raddr_i)) begin
            w_rdata2 = reg_wdata_i;
        end
    end

    assign reg1_rdata_o = w_rdata1;
    assign reg2_rdata_o = w_rdata2;
    assign dbg_rdata_o  = r_dbg_rdata;

    // Array update. A grant never coincides with write-back, so the two
    // write sources cannot collide; entry 0 is never written and stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_pipe_we) begin
            r_regs[reg_waddr_i] <= reg_wdata_i;
        end else if (w_dbg_we) begin
            r_regs[dbg_addr_i] <= dbg_wdata_i;
        end
    end

    // Debug read result is captured at the grant edge and held until the
    // next debug read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dbg_rdata <= '0;
        end else if (w_dbg_re) begin
            r_dbg_rdata <= (dbg_addr_i == ZERO_ADDR) ? '0 : r_regs[dbg_addr_i];
        end
    end

endmodule

// File: tb/tb_regs.sv
// tb_regs
// Scoreboard bench for the register file. Stimulus pushes expected read-port
// values and expected debug completions into queues; a monitor process pops
// and compares on each read strobe and each dbg_ack_o pulse.
module tb_regs;

    logic        clk;
    logic        rst_n;
    logic [4:0]  reg1_raddr;
    logic [4:0]  reg2_raddr;
    logic [31:0] reg1_rdata;
    logic [31:0] reg2_rdata;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        reg_wen;
    logic        dbg_req;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        dbg_hold;

    int checks = 0;
    int errors = 0;
    logic rdStrobe = 1'b0;

    typedef struct {
        string       name;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } rdExp_t;

    typedef struct {
        string       name;
        logic        chkData;
        logic [31:0] expData;
    } ackExp_t;

    rdExp_t  readQ[$];
    ackExp_t ackQ[$];
    rdExp_t  monRd;
    ackExp_t monAck;

    regs #(
        .REG_NUM       (32),
        .ADDR_W        (5),
        .DATA_W        (32),
        .DBG_STARVE_MAX(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .reg1_raddr_i(reg1_raddr),
        .reg2_raddr_i(reg2_raddr),
        .reg1_rdata_o(reg1_rdata),
        .reg2_rdata_o(reg2_rdata),
        .reg_waddr_i (reg_waddr),
        .reg_wdata_i (reg_wdata),
        .reg_wen_i   (reg_wen),
        .dbg_req_i   (dbg_req),
        .dbg_we_i    (dbg_we),
        .dbg_addr_i  (dbg_addr),
        .dbg_wdata_i (dbg_wdata),
        .dbg_ack_o   (dbg_ack),
        .dbg_rdata_o (dbg_rdata),
        .dbg_hold_o  (dbg_hold)
    );

    // Free-running core clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point shared by stimulus and monitor
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares read ports when stimulus strobes them, and every
    // debug ack against the oldest expected completion
    always @(negedge clk) begin
        if (rdStrobe) begin
            if (readQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL readQ empty got strobe expected entry");
            end else begin
                monRd = readQ.pop_front();
                checkOutput({monRd.name, ".p1"}, reg1_rdata, monRd.exp1);
                checkOutput({monRd.name, ".p2"}, reg2_rdata, monRd.exp2);
            end
        end
        if (dbg_ack) begin
            if (ackQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedAck got ack=1 expected ack=0");
            end else begin
                monAck = ackQ.pop_front();
                if (monAck.chkData) begin
                    checkOutput({monAck.name, ".rdata"}, dbg_rdata, monAck.expData);
                end else begin
                    checks++;
                end
            end
        end
    end

    // One cycle of pipeline/read-port stimulus with the expected port values
    task automatic applyStimulus(input string name, input logic wen, input logic [4:0] waddr,
                                 input logic [31:0] wdata, input logic [4:0] ra1, input logic [4:0] ra2,
                                 input logic [31:0] e1, input logic [31:0] e2);
        reg_wen    = wen;
        reg_waddr  = waddr;
        reg_wdata  = wdata;
        reg1_raddr = ra1;
        reg2_raddr = ra2;
        readQ.push_back('{name, e1, e2});
        rdStrobe = 1'b1;
        @(posedge clk);
        #1;
        rdStrobe = 1'b0;
        reg_wen  = 1'b0;
    endtask

    // Full debug handshake with write-back idle; also checks 1-cycle latency
    task automatic dbgAccess(input string name, input logic we, input logic [4:0] addr,
                             input logic [31:0] wdata, input logic chk, input logic [31:0] expData);
        int n;
        ackQ.push_back('{name, chk, expData});
        dbg_req   = 1'b1;
        dbg_we    = we;
        dbg_addr  = addr;
        dbg_wdata = wdata;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            n = k;
            if (dbg_ack) break;
        end
        checkOutput({name, ".latency"}, 32'(n), 32'd2);
        @(posedge clk);
        #1;
        dbg_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Global watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        reg1_raddr = '0;
        reg2_raddr = '0;
        reg_waddr  = '0;
        reg_wdata  = '0;
        reg_wen    = 1'b0;
        dbg_req    = 1'b0;
        dbg_we     = 1'b0;
        dbg_addr   = '0;
        dbg_wdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        checkOutput("rstAck", {31'b0, dbg_ack}, 32'd0);
        checkOutput("rstHold", {31'b0, dbg_hold}, 32'd0);
        checkOutput("rstRdata", dbg_rdata, 32'd0);
        @(posedge clk);
        #1;
        for (int a = 0; a < 32; a++) begin
            applyStimulus($sformatf("rst%0d", a), 1'b0, 5'd0, 32'd0, 5'(a), 5'(31 - a), 32'd0, 32'd0);
        end

        // Forwarding in the write cycle, then array read the next cycle
        applyStimulus("fwd", 1'b1, 5'd5, 32'h0000_1234, 5'd5, 5'd6, 32'h0000_1234, 32'd0);
        applyStimulus("fwdNext", 1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 32'h0000_1234, 32'h0000_1234);

        // x0 ignores pipeline writes, including forwarding
        applyStimulus("x0Pipe", 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 32'd0, 32'd0);
        applyStimulus("x0PipeNext", 1'b0, 5'd0, 32'd0, 5'd0, 5'd5, 32'd0, 32'h0000_1234);

        // Debug write, visible on read port, then debug read back
        dbgAccess("dbgWr10", 1'b1, 5'd10, 32'hCAFE_F00D, 1'b0, 32'd0);
        applyStimulus("rd10", 1'b0, 5'd0, 32'd0, 5'd5, 5'd10, 32'h0000_1234, 32'hCAFE_F00D);
        dbgAccess("dbgRd10", 1'b0, 5'd10, 32'd0, 1'b1, 32'hCAFE_F00D);

        // Debug write to x0 is discarded; debug read of x0 returns zero
        dbgAccess("dbgWr0", 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 32'd0);
        applyStimulus("rd0", 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0);
        dbgAccess("dbgRd0", 1'b0, 5'd0, 32'd0, 1'b1, 32'd0);

        // Starvation: write-back busy for 11 cycles while debug waits
        ackQ.push_back('{"starveGrant", 1'b0, 32'd0});
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 5'd7;
        dbg_wdata = 32'h0000_0077;
        reg_wen   = 1'b1;
        reg_waddr = 5'd3;
        reg_wdata = 32'h0000_0033;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("hold%0d", i), {31'b0, dbg_hold}, (i >= 8) ? 32'd1 : 32'd0);
        end
        @(posedge clk);
        #1;
        reg_wen = 1'b0;
        @(negedge clk);
        checkOutput("holdGrant", {31'b0, dbg_hold}, 32'd1);
        checkOutput("ackGrant", {31'b0, dbg_ack}, 32'd0);
        @(negedge clk);
        checkOutput("holdAck", {31'b0, dbg_hold}, 32'd0);
        checkOutput("ackAck", {31'b0, dbg_ack}, 32'd1);
        @(posedge clk);
        #1;
        dbg_req = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus("starveRd", 1'b0, 5'd0, 32'd0, 5'd7, 5'd3, 32'h0000_0077, 32'h0000_0033);

        // Reset during the grant cycle aborts the access with no ack
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 5'd9;
        dbg_wdata = 32'h0000_0099;
        @(negedge clk);
        checkOutput("abortGrantAck", {31'b0, dbg_ack}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        dbg_req = 1'b0;
        @(negedge clk);
        checkOutput("abortRstAck", {31'b0, dbg_ack}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus("abortRd", 1'b0, 5'd0, 32'd0, 5'd9, 5'd10, 32'd0, 32'd0);
        dbgAccess("reissueWr9", 1'b1, 5'd9, 32'h0000_0099, 1'b0, 32'd0);
        applyStimulus("reissueRd", 1'b0, 5'd0, 32'd0, 5'd9, 5'd7, 32'h0000_0099, 32'd0);

        // Every expected completion must have been consumed
        repeat (2) @(posedge clk);
        checkOutput("ackQEmpty", 32'(ackQ.size()), 32'd0);
        checkOutput("readQEmpty", 32'(readQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
